// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: prioritises memory wait > mul/div > taken branch > load-use into per-stage controls.
// Controls are combinational from state and inputs (same-cycle effect); counters are registered, one cycle behind.
module pipe_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_hazard,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             mdu_start,
    input  logic             clr_cnt,
    output logic             stall_PC,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             bubble_EX,
    output logic             bubble_MEM,
    output logic             bubble_WB,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MDU_CW = $clog2(MDU_CYCLES);
    localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_CYCLES - 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MDU_CW-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic memwait;
    logic mem_act;
    logic mdu_act;
    logic br_act;
    logic lu_act;

    // A memory wait raised during MDU_BUSY still wins the controls; the MDU count runs on underneath.
    always_comb begin
        memwait = dmem_req & ~dmem_ready;
        mem_act = ~rst & ((state_q == MEM_WAIT) | memwait);
        mdu_act = ~rst & ~mem_act &
                  ((state_q == MDU_BUSY) | ((state_q == RUN) & mdu_start));
        br_act  = ~rst & ~mem_act & ~mdu_act & br_taken;
        lu_act  = ~rst & ~mem_act & ~mdu_act & ~br_taken & lu_hazard;

        stall_PC   = mem_act | mdu_act | lu_act;
        stall_ID   = mem_act | mdu_act | lu_act;
        stall_EX   = mem_act | mdu_act;
        stall_MEM  = mem_act;
        bubble_EX  = lu_act;
        bubble_MEM = mdu_act;
        bubble_WB  = mem_act;
        flush_ID   = br_act;
        flush_EX   = br_act;
        mdu_busy   = ~rst & (state_q == MDU_BUSY);
        stall_cnt  = stall_cnt_q;
        flush_cnt  = flush_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            RUN: begin
                if (memwait) begin
                    state_d = MEM_WAIT;
                end else if (mdu_start) begin
                    state_d   = MDU_BUSY;
                    mdu_cnt_d = MDU_LOAD;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end
            end
            MDU_BUSY: begin
                if (mdu_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - MDU_CW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_PC && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_ID && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: drives inputs 1 ns after the rising edge, samples controls on the falling edge.
// Control vector order: {stall_PC, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_MEM, bubble_WB, flush_ID, flush_EX}.
module tb_pipe_ctrl;

    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_MEMW = 9'b111100100;
    localparam logic [8:0] C_MDU  = 9'b111001000;
    localparam logic [8:0] C_BR   = 9'b000000011;
    localparam logic [8:0] C_LU   = 9'b110010000;

    logic       clk = 1'b0;
    logic       rst;
    logic       lu_hazard, br_taken, dmem_req, dmem_ready, mdu_start, clr_cnt;
    logic       stall_PC, stall_ID, stall_EX, stall_MEM;
    logic       bubble_EX, bubble_MEM, bubble_WB, flush_ID, flush_EX, mdu_busy;
    logic [3:0] stall_cnt, flush_cnt;
    logic [8:0] ctl;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.MDU_CYCLES(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .lu_hazard  (lu_hazard),
        .br_taken   (br_taken),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .mdu_start  (mdu_start),
        .clr_cnt    (clr_cnt),
        .stall_PC   (stall_PC),
        .stall_ID   (stall_ID),
        .stall_EX   (stall_EX),
        .stall_MEM  (stall_MEM),
        .bubble_EX  (bubble_EX),
        .bubble_MEM (bubble_MEM),
        .bubble_WB  (bubble_WB),
        .flush_ID   (flush_ID),
        .flush_EX   (flush_EX),
        .mdu_busy   (mdu_busy),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {stall_PC, stall_ID, stall_EX, stall_MEM,
                  bubble_EX, bubble_MEM, bubble_WB, flush_ID, flush_EX};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lu, input logic br, input logic req,
                         input logic rdy, input logic mdu);
        lu_hazard  = lu;
        br_taken   = br;
        dmem_req   = req;
        dmem_ready = rdy;
        mdu_start  = mdu;
    endtask

    task automatic clear_counters();
        drive(0, 0, 0, 0, 0);
        clr_cnt = 1'b1;
        next_cycle();
        clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_cnt = 1'b0;
        drive(1, 0, 1, 0, 1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE) begin
            errors++;
            $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
        end
        checks++;
        if (mdu_busy !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b stall_cnt=%0d flush_cnt=%0d want 0/0/0",
                     mdu_busy, stall_cnt, flush_cnt);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_LU) begin
            errors++;
            $display("FAIL lu_ctl: got %b want %b", ctl, C_LU);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_after: ctl=%b stall_cnt=%0d want %b/1", ctl, stall_cnt, C_NONE);
        end
        next_cycle();
        clear_counters();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, (i == 3), 0);
            @(negedge clk);
            checks++;
            if (ctl !== C_MEMW || mdu_busy !== 1'b0) begin
                errors++;
                $display("FAIL memw_cycle%0d: ctl=%b busy=%b want %b/0", i + 1, ctl, mdu_busy, C_MEMW);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL memw_after: ctl=%b stall_cnt=%0d want %b/4", ctl, stall_cnt, C_NONE);
        end
        next_cycle();
        clear_counters();
    endtask

    task automatic test_mdu();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            @(negedge clk);
            checks++;
            if (ctl !== C_MDU || mdu_busy !== (i > 0)) begin
                errors++;
                $display("FAIL mdu_cycle%0d: ctl=%b busy=%b want %b/%0d", i + 1, ctl, mdu_busy, C_MDU, (i > 0));
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || mdu_busy !== 1'b0 || stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL mdu_after: ctl=%b busy=%b stall_cnt=%0d want %b/0/4",
                     ctl, mdu_busy, stall_cnt, C_NONE);
        end
        next_cycle();
        clear_counters();
    endtask

    task automatic test_branch_lu();
        drive(1, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_BR) begin
            errors++;
            $display("FAIL br_lu_ctl: got %b want %b", ctl, C_BR);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL br_lu_cnt: flush_cnt=%0d stall_cnt=%0d want 1/0", flush_cnt, stall_cnt);
        end
        next_cycle();
        clear_counters();
    endtask

    task automatic test_branch_memwait();
        drive(0, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_MEMW) begin
            errors++;
            $display("FAIL br_memw_c1: got %b want %b", ctl, C_MEMW);
        end
        next_cycle();
        drive(0, 1, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_MEMW) begin
            errors++;
            $display("FAIL br_memw_c2: got %b want %b", ctl, C_MEMW);
        end
        next_cycle();
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_BR) begin
            errors++;
            $display("FAIL br_memw_flush: got %b want %b", ctl, C_BR);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL br_memw_after: ctl=%b flush_cnt=%0d stall_cnt=%0d want %b/1/2",
                     ctl, flush_cnt, stall_cnt, C_NONE);
        end
        next_cycle();
        clear_counters();
    endtask

    // mul/div op interrupted by a memory wait: MDU count expires underneath, then MEM_WAIT is entered from RUN.
    task automatic test_back_to_back();
        logic       req_v [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic       rdy_v [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic       mdu_v [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [8:0] ctl_v [7] = '{C_MDU, C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_NONE};
        logic       bsy_v [7] = '{0, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, req_v[i], rdy_v[i], mdu_v[i]);
            @(negedge clk);
            checks++;
            if (ctl !== ctl_v[i] || mdu_busy !== bsy_v[i]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ctl=%b busy=%b want %b/%b",
                         i + 1, ctl, mdu_busy, ctl_v[i], bsy_v[i]);
            end
            next_cycle();
        end
        checks++;
        if (stall_cnt !== 4'd6) begin
            errors++;
            $display("FAIL b2b_cnt: stall_cnt=%0d want 6", stall_cnt);
        end
        clear_counters();
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_now: ctl=%b busy=%b want %b/0", ctl, mdu_busy, C_NONE);
        end
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (ctl !== C_NONE || mdu_busy !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_after: ctl=%b busy=%b stall_cnt=%0d want %b/0/0",
                     ctl, mdu_busy, stall_cnt, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt: stall_cnt=%0d want 15", stall_cnt);
        end
        next_cycle();
        drive(1, 0, 0, 0, 0);
        clr_cnt = 1'b1;
        next_cycle();
        clr_cnt = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr: stall_cnt=%0d want 0", stall_cnt);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_mdu();
        test_branch_lu();
        test_branch_memwait();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
